// File: rtl/dcache_mshr.sv
// dcache_mshr: data-cache controller with miss status holding registers between the LSQ and a tagged memory bus.
// Optional build macro DCACHE_MSHR_MERGE_EN: a load miss to an address already pending shares that entry's fill.
module dcache_mshr #(
    parameter int MSHR_NUM  = 4,
    parameter int ADDR_W    = 64,
    parameter int MEM_TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lsq2Dcache_ld_en_i,
    input  logic [ADDR_W-1:0]    lsq2Dcache_ld_addr_i,
    input  logic                 lsq2Dcache_st_en_i,
    input  logic [ADDR_W-1:0]    lsq2Dcache_st_addr_i,
    input  logic [63:0]          lsq2Dcache_st_data_i,
    input  logic                 cachemem_hit_i,
    input  logic [63:0]          cachemem_data_i,
    output logic [ADDR_W-1:0]    cachemem_rd_addr_o,
    output logic                 cachemem_wr_en_o,
    output logic [ADDR_W-1:0]    cachemem_wr_addr_o,
    output logic [63:0]          cachemem_wr_data_o,
    output logic [1:0]           proc2mem_command_o,
    output logic [ADDR_W-1:0]    proc2mem_addr_o,
    output logic [63:0]          proc2mem_data_o,
    input  logic [MEM_TAG_W-1:0] mem2proc_response_i,
    input  logic [MEM_TAG_W-1:0] mem2proc_tag_i,
    input  logic [63:0]          mem2proc_data_i,
    output logic                 Dcache_hit_o,
    output logic [63:0]          Dcache_data_o,
    output logic                 Dcache_mshr_ld_ack_o,
    output logic                 Dcache_mshr_st_ack_o,
    output logic                 Dcache_mshr_vld_o,
    output logic [ADDR_W-1:0]    Dcache_mshr_addr_o,
    output logic                 Dcache_mshr_stall_o
);
    localparam int IW = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;
    localparam int CW = $clog2(MSHR_NUM + 1);
    typedef enum logic [1:0] {FREE, PEND, DONE} ent_e;
    ent_e                 st_q   [MSHR_NUM];
    ent_e                 st_d   [MSHR_NUM];
    logic [ADDR_W-1:0]    addr_q [MSHR_NUM];
    logic [ADDR_W-1:0]    addr_d [MSHR_NUM];
    logic [MEM_TAG_W-1:0] tag_q  [MSHR_NUM];
    logic [MEM_TAG_W-1:0] tag_d  [MSHR_NUM];
    logic [63:0]          data_q [MSHR_NUM];
    logic [63:0]          data_d [MSHR_NUM];
    logic                 stall_q, stall_d;
    logic                 done_any, free_any, st_conf;
    logic [IW-1:0]        done_idx, free_idx;
    logic [CW-1:0]        free_cnt;
    logic                 st_go, ld_try, ld_hit, ld_bus, resp_ok, alloc, merge, st_wr;

    // Scan entries: lowest DONE and FREE entry, and store address hazards against live entries
    always_comb begin
        done_any = 1'b0;
        done_idx = '0;
        free_any = 1'b0;
        free_idx = '0;
        st_conf  = 1'b0;
        for (int i = MSHR_NUM - 1; i >= 0; i--) begin
            if (st_q[i] == DONE) begin
                done_any = 1'b1;
                done_idx = IW'(i);
            end
            if (st_q[i] == FREE) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
            if (st_q[i] != FREE && addr_q[i] == lsq2Dcache_st_addr_i) st_conf = 1'b1;
        end
    end

    assign resp_ok = mem2proc_response_i != '0;
    assign st_go   = lsq2Dcache_st_en_i && !done_any && !st_conf;
    assign ld_try  = lsq2Dcache_ld_en_i && !st_go && !done_any;
    assign ld_hit  = ld_try && cachemem_hit_i;

`ifdef DCACHE_MSHR_MERGE_EN
    logic ld_pend;
    // A miss to an address already in flight rides on that entry's broadcast
    always_comb begin
        ld_pend = 1'b0;
        for (int i = 0; i < MSHR_NUM; i++)
            if (st_q[i] == PEND && addr_q[i] == lsq2Dcache_ld_addr_i) ld_pend = 1'b1;
    end
    assign merge = ld_try && !cachemem_hit_i && ld_pend;
`else
    assign merge = 1'b0;
`endif

    assign ld_bus = ld_try && !cachemem_hit_i && !merge && free_any;
    assign alloc  = ld_bus && resp_ok;
    assign st_wr  = st_go && resp_ok && cachemem_hit_i;

    assign cachemem_rd_addr_o   = st_go ? lsq2Dcache_st_addr_i : lsq2Dcache_ld_addr_i;
    assign proc2mem_command_o   = st_go ? 2'd2 : ld_bus ? 2'd1 : 2'd0;
    assign proc2mem_addr_o      = st_go ? lsq2Dcache_st_addr_i : ld_bus ? lsq2Dcache_ld_addr_i : '0;
    assign proc2mem_data_o      = st_go ? lsq2Dcache_st_data_i : '0;
    assign Dcache_hit_o         = ld_hit;
    assign Dcache_data_o        = done_any ? data_q[done_idx] : ld_hit ? cachemem_data_i : '0;
    assign Dcache_mshr_ld_ack_o = alloc || merge;
    assign Dcache_mshr_st_ack_o = st_go && resp_ok;
    assign Dcache_mshr_vld_o    = done_any;
    assign Dcache_mshr_addr_o   = done_any ? addr_q[done_idx] : '0;
    assign Dcache_mshr_stall_o  = stall_q;
    assign cachemem_wr_en_o     = done_any || st_wr;
    assign cachemem_wr_addr_o   = done_any ? addr_q[done_idx] : st_wr ? lsq2Dcache_st_addr_i : '0;
    assign cachemem_wr_data_o   = done_any ? data_q[done_idx] : st_wr ? lsq2Dcache_st_data_i : '0;

    // Entry transitions: DONE retires, PEND completes on tag match, lowest FREE takes a new miss
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < MSHR_NUM; i++) begin
            st_d[i]   = st_q[i];
            addr_d[i] = addr_q[i];
            tag_d[i]  = tag_q[i];
            data_d[i] = data_q[i];
            if (st_q[i] == DONE) begin
                st_d[i] = FREE;
            end else if (st_q[i] == PEND && mem2proc_tag_i != '0 && tag_q[i] == mem2proc_tag_i) begin
                st_d[i]   = DONE;
                data_d[i] = mem2proc_data_i;
            end else if (alloc && free_idx == IW'(i)) begin
                st_d[i]   = PEND;
                addr_d[i] = lsq2Dcache_ld_addr_i;
                tag_d[i]  = mem2proc_response_i;
            end
            free_cnt = free_cnt + CW'(st_d[i] == FREE);
        end
        stall_d = free_cnt <= CW'(1);
    end

    // Entry and stall registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSHR_NUM; i++) begin
                st_q[i]   <= FREE;
                addr_q[i] <= '0;
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            stall_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_dcache_mshr.sv
// tb_dcache_mshr: directed vector bench for dcache_mshr (honours DCACHE_MSHR_MERGE_EN when defined).
module tb_dcache_mshr;
    logic        clk = 1'b0;
    logic        rst, ld_en, st_en, hit_i;
    logic [63:0] ld_addr, st_addr, st_data, cdata_i, mdata;
    logic [3:0]  resp, mtag;
    logic [63:0] rd_addr, wr_addr, wr_data, paddr, pdata, dout, maddr;
    logic [1:0]  cmd;
    logic        wr_en, hit_o, lack, sack, vld, stall;
    int          nvec = 0;
    int          nbad = 0;

    typedef struct {
        logic r, ld; logic [63:0] la; logic st; logic [63:0] sa, sd; logic h; logic [63:0] cd;
        logic [3:0] rsp, tg; logic [63:0] md;
        logic [1:0] cmd; logic [63:0] pa; logic ho; logic [63:0] dout; logic lack, sack, vld;
        logic [63:0] maddr; logic wen; logic [63:0] waddr, wdata; logic stall;
    } vec_t;
    vec_t vecs[$];

    dcache_mshr dut (
        .clk(clk), .rst(rst),
        .lsq2Dcache_ld_en_i(ld_en), .lsq2Dcache_ld_addr_i(ld_addr),
        .lsq2Dcache_st_en_i(st_en), .lsq2Dcache_st_addr_i(st_addr), .lsq2Dcache_st_data_i(st_data),
        .cachemem_hit_i(hit_i), .cachemem_data_i(cdata_i), .cachemem_rd_addr_o(rd_addr),
        .cachemem_wr_en_o(wr_en), .cachemem_wr_addr_o(wr_addr), .cachemem_wr_data_o(wr_data),
        .proc2mem_command_o(cmd), .proc2mem_addr_o(paddr), .proc2mem_data_o(pdata),
        .mem2proc_response_i(resp), .mem2proc_tag_i(mtag), .mem2proc_data_i(mdata),
        .Dcache_hit_o(hit_o), .Dcache_data_o(dout), .Dcache_mshr_ld_ack_o(lack),
        .Dcache_mshr_st_ack_o(sack), .Dcache_mshr_vld_o(vld), .Dcache_mshr_addr_o(maddr),
        .Dcache_mshr_stall_o(stall)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic ld, logic [63:0] la, logic st, logic [63:0] sa, logic [63:0] sd,
                                logic h, logic [63:0] cd, logic [3:0] rsp, logic [3:0] tg, logic [63:0] md,
                                logic [1:0] c, logic [63:0] pa, logic ho, logic [63:0] dt, logic la_, logic sa_,
                                logic v, logic [63:0] ma, logic we, logic [63:0] wa, logic [63:0] wd, logic s);
        vec_t x;
        x.r = r; x.ld = ld; x.la = la; x.st = st; x.sa = sa; x.sd = sd; x.h = h; x.cd = cd;
        x.rsp = rsp; x.tg = tg; x.md = md; x.cmd = c; x.pa = pa; x.ho = ho; x.dout = dt;
        x.lack = la_; x.sack = sa_; x.vld = v; x.maddr = ma; x.wen = we; x.waddr = wa; x.wdata = wd; x.stall = s;
        return x;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.r; ld_en = v.ld; ld_addr = v.la; st_en = v.st; st_addr = v.sa; st_data = v.sd;
        hit_i = v.h; cdata_i = v.cd; resp = v.rsp; mtag = v.tg; mdata = v.md;
    endtask

    task automatic check(input string name, input vec_t e);
        logic ok;
        ok = cmd == e.cmd && (e.cmd == 2'd0 || paddr == e.pa) && hit_o == e.ho &&
             ((!e.ho && !e.vld) || dout == e.dout) && lack == e.lack && sack == e.sack &&
             vld == e.vld && (!e.vld || maddr == e.maddr) && wr_en == e.wen &&
             (!e.wen || (wr_addr == e.waddr && wr_data == e.wdata)) && stall == e.stall;
        nvec++;
        if (!ok) begin
            nbad++;
            $display("FAIL %s: got cmd=%0d pa=%h hit=%b dout=%h lack=%b sack=%b vld=%b maddr=%h wen=%b waddr=%h wdata=%h stall=%b | want cmd=%0d pa=%h hit=%b dout=%h lack=%b sack=%b vld=%b maddr=%h wen=%b waddr=%h wdata=%h stall=%b",
                     name, cmd, paddr, hit_o, dout, lack, sack, vld, maddr, wr_en, wr_addr, wr_data, stall,
                     e.cmd, e.pa, e.ho, e.dout, e.lack, e.sack, e.vld, e.maddr, e.wen, e.waddr, e.wdata, e.stall);
        end
    endtask

    initial begin
        vec_t e;
        int   n;
        // r ld la st sa sd h cd rsp tg md | cmd pa ho dout lack sack vld maddr wen waddr wdata stall
        vecs.push_back(mk(1,0,'0,0,'0,'0,0,'0,0,0,'0,            0,'0,0,'0,0,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,0,'0,            0,'0,0,'0,0,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,1,64'h100,0,'0,'0,1,64'hAB,0,0,'0,   0,'0,1,64'hAB,0,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,1,64'h200,0,'0,'0,0,'0,4'd3,0,'0,    1,64'h200,0,'0,1,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,0,'0,            0,'0,0,'0,0,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,4'd3,64'h55,     0,'0,0,'0,0,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,0,'0,            0,'0,0,64'h55,0,0,1,64'h200,1,64'h200,64'h55,0));
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,0,'0,            0,'0,0,'0,0,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,1,64'h1000,0,'0,'0,0,'0,4'd1,0,'0,   1,64'h1000,0,'0,1,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,1,64'h1008,0,'0,'0,0,'0,4'd2,0,'0,   1,64'h1008,0,'0,1,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,1,64'h1010,0,'0,'0,0,'0,4'd3,0,'0,   1,64'h1010,0,'0,1,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,1,64'h1018,0,'0,'0,0,'0,4'd4,0,'0,   1,64'h1018,0,'0,1,0,0,'0,0,'0,'0,1));
        vecs.push_back(mk(0,1,64'h1020,0,'0,'0,0,'0,4'd5,0,'0,   0,'0,0,'0,0,0,0,'0,0,'0,'0,1));
        vecs.push_back(mk(0,0,'0,1,64'h2000,64'hDEAD,1,'0,4'd6,0,'0, 2,64'h2000,0,'0,0,1,0,'0,1,64'h2000,64'hDEAD,1));
        vecs.push_back(mk(0,1,64'h1020,0,'0,'0,0,'0,4'd5,4'd2,64'h77, 0,'0,0,'0,0,0,0,'0,0,'0,'0,1));
        vecs.push_back(mk(0,1,64'h1020,0,'0,'0,0,'0,4'd5,0,'0,   0,'0,0,64'h77,0,0,1,64'h1008,1,64'h1008,64'h77,1));
        vecs.push_back(mk(0,1,64'h1020,0,'0,'0,0,'0,4'd5,0,'0,   1,64'h1020,0,'0,1,0,0,'0,0,'0,'0,1));
        vecs.push_back(mk(0,0,'0,1,64'h1010,64'h99,1,'0,4'd7,0,'0, 0,'0,0,'0,0,0,0,'0,0,'0,'0,1));
        vecs.push_back(mk(0,0,'0,1,64'h1010,64'h99,1,'0,4'd7,4'd3,64'h33, 0,'0,0,'0,0,0,0,'0,0,'0,'0,1));
        vecs.push_back(mk(0,0,'0,1,64'h1010,64'h99,1,'0,4'd7,0,'0, 0,'0,0,64'h33,0,0,1,64'h1010,1,64'h1010,64'h33,1));
        vecs.push_back(mk(0,0,'0,1,64'h1010,64'h99,1,'0,4'd7,0,'0, 2,64'h1010,0,'0,0,1,0,'0,1,64'h1010,64'h99,1));
        vecs.push_back(mk(0,1,64'h1100,1,64'h3000,64'h1234,1,64'hAA,4'd5,0,'0, 2,64'h3000,0,'0,0,1,0,'0,1,64'h3000,64'h1234,1));
        vecs.push_back(mk(0,0,'0,1,64'h3008,64'h5,1,'0,4'd0,0,'0, 2,64'h3008,0,'0,0,0,0,'0,0,'0,'0,1));
        vecs.push_back(mk(0,1,64'h1200,0,'0,'0,0,'0,4'd0,0,'0,   1,64'h1200,0,'0,0,0,0,'0,0,'0,'0,1));
        vecs.push_back(mk(1,0,'0,0,'0,'0,0,'0,0,0,'0,            0,'0,0,'0,0,0,0,'0,0,'0,'0,1));
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,4'd1,64'hEE,     0,'0,0,'0,0,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,0,'0,            0,'0,0,'0,0,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,1,64'h300,0,'0,'0,0,'0,4'd1,0,'0,    1,64'h300,0,'0,1,0,0,'0,0,'0,'0,0));
`ifdef DCACHE_MSHR_MERGE_EN
        vecs.push_back(mk(0,1,64'h300,0,'0,'0,0,'0,4'd2,0,'0,    0,'0,0,'0,1,0,0,'0,0,'0,'0,0));
`else
        vecs.push_back(mk(0,1,64'h300,0,'0,'0,0,'0,4'd2,0,'0,    1,64'h300,0,'0,1,0,0,'0,0,'0,'0,0));
`endif
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,4'd1,64'hCC,     0,'0,0,'0,0,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,1,64'h500,0,'0,'0,1,64'hFF,0,0,'0,   0,'0,0,64'hCC,0,0,1,64'h300,1,64'h300,64'hCC,0));
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,4'd2,64'hDD,     0,'0,0,'0,0,0,0,'0,0,'0,'0,0));
`ifdef DCACHE_MSHR_MERGE_EN
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,0,'0,            0,'0,0,'0,0,0,0,'0,0,'0,'0,0));
`else
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,0,'0,            0,'0,0,64'hDD,0,0,1,64'h300,1,64'h300,64'hDD,0));
`endif
        vecs.push_back(mk(0,1,64'h400,0,'0,'0,0,'0,4'd6,0,'0,    1,64'h400,0,'0,1,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,1,64'h408,0,'0,'0,0,'0,4'd7,4'd6,64'h66, 1,64'h408,0,'0,1,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,0,'0,            0,'0,0,64'h66,0,0,1,64'h400,1,64'h400,64'h66,0));
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,4'd7,64'h67,     0,'0,0,'0,0,0,0,'0,0,'0,'0,0));
        vecs.push_back(mk(0,0,'0,0,'0,'0,0,'0,0,0,'0,            0,'0,0,64'h67,0,0,1,64'h408,1,64'h408,64'h67,0));

        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #3;
            check($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk);
            #1;
        end

        e = mk(0,1,64'h600,0,'0,'0,0,'0,4'd9,0,'0, 1,64'h600,0,'0,1,0,0,'0,0,'0,'0,0);
        drive(e);
        #3;
        check("fill_issue", e);
        @(posedge clk);
        #1;
        e = mk(0,0,'0,0,'0,'0,0,'0,0,4'd9,64'h6060, 0,'0,0,'0,0,0,0,'0,0,'0,'0,0);
        drive(e);
        #3;
        check("fill_tag", e);
        @(posedge clk);
        #1;
        drive(mk(0,0,'0,0,'0,'0,0,'0,0,0,'0, 0,'0,0,'0,0,0,0,'0,0,'0,'0,0));
        n = 0;
        while (!vld && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        nvec++;
        if (n != 0 || !vld || dout != 64'h6060 || maddr != 64'h600) begin
            nbad++;
            $display("FAIL fill_latency: got extra_cycles=%0d vld=%b dout=%h maddr=%h | want extra_cycles=0 vld=1 dout=6060 maddr=600", n, vld, dout, maddr);
        end
        @(posedge clk);
        #1;
        nvec++;
        if (vld) begin
            nbad++;
            $display("FAIL fill_once: got vld=%b | want vld=0", vld);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
